// File: rtl/scheduler_vote.sv
// Ring of per-axon saturating vote counters; a set delivers the current slot as a spike vector.
// Latency: a write or set at edge n is visible on the outputs after edge n+1.
// Backpressure: none; writes are always accepted, and writes during a flush are dropped and flagged.
module scheduler_vote #(
  parameter int NUM_AXONS = 256,
  parameter int NUM_TICKS = 16,
  parameter int VOTE_NUM  = 1,
  parameter int NUM_PORTS = 2,
  localparam int AW = $clog2(NUM_AXONS),
  localparam int TW = $clog2(NUM_TICKS),
  localparam int CW = $clog2(VOTE_NUM + 1),
  localparam int PW = AW + TW
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_PORTS-1:0]    wen,
  input  logic [NUM_PORTS*PW-1:0] packet,
  input  logic                   set,
  input  logic                   clr,
  input  logic                   clr_avr,
  input  logic                   clr_spiked,
  output logic [NUM_AXONS-1:0]    axon_spikes,
  output logic [NUM_AXONS-1:0]    fired_mask,
  output logic [TW-1:0]           rd_ptr,
  output logic                   error
);

  localparam logic [CW-1:0] VOTE_MAX = CW'(VOTE_NUM);

  typedef logic [NUM_AXONS-1:0][CW-1:0] slot_t;

  slot_t [NUM_TICKS-1:0] cnt_q;
  slot_t [NUM_TICKS-1:0] cnt_d;
  logic  [NUM_AXONS-1:0] deliver;

  logic [AW-1:0] pkt_axon [NUM_PORTS];
  logic [TW-1:0] pkt_slot [NUM_PORTS];

  // Slot is relative to the pointer before any same-cycle advance; the add wraps mod NUM_TICKS.
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    assign pkt_axon[p] = packet[p*PW + TW +: AW];
    assign pkt_slot[p] = rd_ptr + packet[p*PW +: TW];
  end

  // Apply this cycle's votes (saturating, ports accumulate in turn), then sample and zero the delivered slot.
  always_comb begin
    cnt_d   = cnt_q;
    deliver = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (wen[p] && (cnt_d[pkt_slot[p]][pkt_axon[p]] < VOTE_MAX)) begin
        cnt_d[pkt_slot[p]][pkt_axon[p]] = cnt_d[pkt_slot[p]][pkt_axon[p]] + CW'(1);
      end
    end
    // Counters never exceed VOTE_MAX, so equality is the threshold test.
    for (int i = 0; i < NUM_AXONS; i++) begin
      deliver[i] = (cnt_d[rd_ptr][i] == VOTE_MAX);
    end
    if (set) begin
      cnt_d[rd_ptr] = '0;
    end
  end

  // State update: flush has top priority, then set, then the individual clears.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q       <= '0;
      rd_ptr      <= '0;
      axon_spikes <= '0;
      fired_mask  <= '0;
      error       <= 1'b0;
    end else if (clr_avr) begin
      cnt_q       <= '0;
      rd_ptr      <= '0;
      axon_spikes <= '0;
      if (|wen) begin
        error <= 1'b1;
      end
    end else begin
      cnt_q <= cnt_d;
      if (set) begin
        axon_spikes <= deliver;
        rd_ptr      <= rd_ptr + TW'(1);
        fired_mask  <= (clr_spiked ? '0 : fired_mask) | deliver;
      end else begin
        if (clr) begin
          axon_spikes <= '0;
        end
        if (clr_spiked) begin
          fired_mask <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_scheduler_vote.sv
module tb_scheduler_vote;

  localparam int NA = 256;
  localparam int TW = 4;
  localparam int PW = 8 + TW;

  logic          clk;
  logic          rst;
  logic [1:0]    wen;
  logic [2*PW-1:0] packet;
  logic          set;
  logic          clr;
  logic          clr_avr;
  logic          clr_spiked;

  logic [NA-1:0] sp1, fm1, sp2, fm2, sp3, fm3;
  logic [TW-1:0] rp1, rp2, rp3;
  logic          er1, er2, er3;

  int checks = 0;
  int errors = 0;

  scheduler_vote #(.VOTE_NUM(1)) u1 (
    .clk(clk), .rst(rst), .wen(wen), .packet(packet), .set(set), .clr(clr),
    .clr_avr(clr_avr), .clr_spiked(clr_spiked),
    .axon_spikes(sp1), .fired_mask(fm1), .rd_ptr(rp1), .error(er1)
  );

  scheduler_vote #(.VOTE_NUM(2)) u2 (
    .clk(clk), .rst(rst), .wen(wen), .packet(packet), .set(set), .clr(clr),
    .clr_avr(clr_avr), .clr_spiked(clr_spiked),
    .axon_spikes(sp2), .fired_mask(fm2), .rd_ptr(rp2), .error(er2)
  );

  scheduler_vote #(.VOTE_NUM(3)) u3 (
    .clk(clk), .rst(rst), .wen(wen), .packet(packet), .set(set), .clr(clr),
    .clr_avr(clr_avr), .clr_spiked(clr_spiked),
    .axon_spikes(sp3), .fired_mask(fm3), .rd_ptr(rp3), .error(er3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [NA-1:0] onehot(input int k);
    logic [NA-1:0] v;
    v = '0;
    v[k] = 1'b1;
    return v;
  endfunction

  // Queue one packet on a port for the next edge.
  task automatic drive_pkt(input int port, input logic [7:0] axon, input logic [TW-1:0] dtick);
    wen[port] = 1'b1;
    packet[port*PW +: PW] = {axon, dtick};
  endtask

  // Advance one edge, sample point is 1ns after it; pulse inputs are dropped.
  task automatic cycle();
    @(posedge clk);
    #1;
    wen = '0; packet = '0; set = 1'b0; clr = 1'b0; clr_avr = 1'b0; clr_spiked = 1'b0;
  endtask

  task automatic do_set();
    set = 1'b1;
    cycle();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    wen = '0; packet = '0; set = 1'b0; clr = 1'b0; clr_avr = 1'b0; clr_spiked = 1'b0;
    #2;
    checks++;
    if ({sp1, fm1, rp1, er1, sp3, fm3, rp3, er3} !== '0) begin
      errors++; $display("FAIL reset_outputs: got sp=%h rp=%0d er=%b required all zero", sp1, rp1, er1);
    end
    @(negedge clk);
    rst = 1'b1;
    cycle();
  endtask

  task automatic test_single_vote();
    drive_pkt(0, 8'd5, 4'd0);
    cycle();
    do_set();
    checks++;
    if (sp1 !== onehot(5)) begin errors++; $display("FAIL single_spikes: got %h required %h", sp1, onehot(5)); end
    checks++;
    if (fm1[5] !== 1'b1) begin errors++; $display("FAIL single_mask: got %b required 1", fm1[5]); end
    checks++;
    if (rp1 !== 4'd1) begin errors++; $display("FAIL single_rdptr: got %0d required 1", rp1); end
    checks++;
    if (sp2 !== '0) begin errors++; $display("FAIL single_vote2: got %h required 0", sp2); end
    do_set();
    checks++;
    if (sp1 !== '0) begin errors++; $display("FAIL single_second_set: got %h required 0", sp1); end
    clr_spiked = 1'b1;
    cycle();
    checks++;
    if (fm1 !== '0) begin errors++; $display("FAIL single_clr_spiked: got %h required 0", fm1); end
  endtask

  task automatic test_voting();
    // rd_ptr = 2: three votes land in slot 4.
    drive_pkt(0, 8'd7, 4'd2);
    drive_pkt(1, 8'd7, 4'd2);
    cycle();
    drive_pkt(0, 8'd7, 4'd2);
    cycle();
    for (int s = 0; s < 2; s++) begin
      do_set();
      checks++;
      if (sp3 !== '0) begin errors++; $display("FAIL vote_early_set%0d: got %h required 0", s, sp3); end
    end
    do_set();
    checks++;
    if (sp3 !== onehot(7)) begin errors++; $display("FAIL vote_third_set: got %h required %h", sp3, onehot(7)); end
    checks++;
    if (sp1 !== onehot(7)) begin errors++; $display("FAIL vote_sat1: got %h required %h", sp1, onehot(7)); end
    // rd_ptr = 5: two votes land in slot 7.
    drive_pkt(0, 8'd7, 4'd2);
    drive_pkt(1, 8'd7, 4'd2);
    cycle();
    repeat (3) do_set();
    checks++;
    if (sp3 !== '0) begin errors++; $display("FAIL vote_two_of_three: got %h required 0", sp3); end
    checks++;
    if (sp2 !== onehot(7)) begin errors++; $display("FAIL vote_two_of_two: got %h required %h", sp2, onehot(7)); end
    checks++;
    if (rp3 !== 4'd8) begin errors++; $display("FAIL vote_rdptr: got %0d required 8", rp3); end
  endtask

  task automatic test_saturate();
    // Four votes into a 2-bit counter would wrap to zero without saturation.
    repeat (2) begin
      drive_pkt(0, 8'd12, 4'd0);
      drive_pkt(1, 8'd12, 4'd0);
      cycle();
    end
    do_set();
    checks++;
    if (sp2 !== onehot(12)) begin errors++; $display("FAIL saturate_vote2: got %h required %h", sp2, onehot(12)); end
    checks++;
    if (sp3 !== onehot(12)) begin errors++; $display("FAIL saturate_vote3: got %h required %h", sp3, onehot(12)); end
  endtask

  task automatic test_same_cycle();
    // rd_ptr = 9.
    drive_pkt(0, 8'd3, 4'd0);
    cycle();
    drive_pkt(0, 8'd3, 4'd0);
    do_set();
    checks++;
    if (sp2 !== onehot(3)) begin errors++; $display("FAIL same_cycle_deliver: got %h required %h", sp2, onehot(3)); end
    for (int s = 0; s < 16; s++) begin
      do_set();
      checks++;
      if ((sp1 | sp2 | sp3) !== '0) begin errors++; $display("FAIL same_cycle_zeroed set%0d: got %h required 0", s, sp1 | sp2); end
    end
    checks++;
    if (rp2 !== 4'd10) begin errors++; $display("FAIL same_cycle_rdptr: got %0d required 10", rp2); end
  endtask

  task automatic test_wrap();
    repeat (5) do_set();
    checks++;
    if (rp1 !== 4'd15) begin errors++; $display("FAIL wrap_start_ptr: got %0d required 15", rp1); end
    drive_pkt(1, 8'd9, 4'd3);
    cycle();
    for (int s = 0; s < 3; s++) begin
      do_set();
      checks++;
      if (sp1 !== '0) begin errors++; $display("FAIL wrap_early_set%0d: got %h required 0", s, sp1); end
    end
    do_set();
    checks++;
    if (sp1 !== onehot(9)) begin errors++; $display("FAIL wrap_fire: got %h required %h", sp1, onehot(9)); end
    checks++;
    if (rp1 !== 4'd3) begin errors++; $display("FAIL wrap_end_ptr: got %0d required 3", rp1); end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 3; k++) begin
      drive_pkt(0, 8'(10 + k), 4'd0);
      do_set();
      checks++;
      if (sp1 !== onehot(10 + k)) begin errors++; $display("FAIL b2b_set%0d: got %h required %h", k, sp1, onehot(10 + k)); end
    end
  endtask

  task automatic test_clr_priority();
    drive_pkt(0, 8'd20, 4'd0);
    clr = 1'b1;
    do_set();
    checks++;
    if (sp1 !== onehot(20)) begin errors++; $display("FAIL clr_set_wins: got %h required %h", sp1, onehot(20)); end
    clr = 1'b1;
    cycle();
    checks++;
    if (sp1 !== '0) begin errors++; $display("FAIL clr_alone: got %h required 0", sp1); end
    drive_pkt(0, 8'd21, 4'd0);
    clr_spiked = 1'b1;
    do_set();
    checks++;
    if (fm1 !== onehot(21)) begin errors++; $display("FAIL clr_spiked_with_set: got %h required %h", fm1, onehot(21)); end
  endtask

  task automatic test_flush();
    checks++;
    if (er1 !== 1'b0) begin errors++; $display("FAIL flush_error_before: got %b required 0", er1); end
    for (int d = 0; d < 6; d++) begin
      drive_pkt(0, 8'(30 + d), 4'(d));
      cycle();
    end
    drive_pkt(0, 8'd40, 4'd0);
    clr_avr = 1'b1;
    set = 1'b1;
    cycle();
    checks++;
    if (rp1 !== 4'd0) begin errors++; $display("FAIL flush_rdptr: got %0d required 0", rp1); end
    checks++;
    if (er1 !== 1'b1) begin errors++; $display("FAIL flush_error: got %b required 1", er1); end
    checks++;
    if (sp1 !== '0) begin errors++; $display("FAIL flush_spikes: got %h required 0", sp1); end
    for (int s = 0; s < 6; s++) begin
      do_set();
      checks++;
      if (sp1 !== '0) begin errors++; $display("FAIL flush_slot%0d: got %h required 0", s, sp1); end
    end
    checks++;
    if (fm1 !== onehot(21)) begin errors++; $display("FAIL flush_mask_kept: got %h required %h", fm1, onehot(21)); end
    clr_spiked = 1'b1;
    cycle();
    checks++;
    if (fm1 !== '0) begin errors++; $display("FAIL flush_mask_cleared: got %h required 0", fm1); end
    checks++;
    if (er1 !== 1'b1) begin errors++; $display("FAIL flush_error_sticky: got %b required 1", er1); end
  endtask

  task automatic test_async_reset();
    drive_pkt(0, 8'd50, 4'd0);
    do_set();
    drive_pkt(0, 8'd51, 4'd0);
    cycle();
    checks++;
    if (sp1 !== onehot(50)) begin errors++; $display("FAIL async_pre: got %h required %h", sp1, onehot(50)); end
    #3;
    rst = 1'b0;
    #1;
    checks++;
    if ({sp1, fm1, rp1, er1} !== '0) begin
      errors++; $display("FAIL async_reset_outputs: got sp=%h fm=%h rp=%0d er=%b required all zero", sp1, fm1, rp1, er1);
    end
    @(negedge clk);
    rst = 1'b1;
    do_set();
    checks++;
    if (sp1 !== '0) begin errors++; $display("FAIL async_after_release: got %h required 0", sp1); end
    checks++;
    if (rp1 !== 4'd1) begin errors++; $display("FAIL async_rdptr: got %0d required 1", rp1); end
  endtask

  initial begin
    test_reset();
    test_single_vote();
    test_voting();
    test_saturate();
    test_same_cycle();
    test_wrap();
    test_back_to_back();
    test_clr_priority();
    test_flush();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule

// File: doc/scheduler_vote.md
Name: scheduler_vote

Overview:
- Parametrised successor to the core's axon scheduler: a NUM_TICKS-deep ring of per-axon saturating vote counters fed by up to NUM_PORTS router packets per cycle.
- On each tick it delivers a NUM_AXONS-wide spike vector to the token controller. An axon fires only when it has collected VOTE_NUM or more packets for that tick.
- Adds multi-port writes, vote thresholding, a sticky fired mask and a full flush, none of which the single-port bit scheduler provides.

Parameters:
NUM_AXONS, 256, axons per core; must be a power of two; AW = $clog2(NUM_AXONS)
NUM_TICKS, 16, ring depth; must be a power of two; TW = $clog2(NUM_TICKS)
VOTE_NUM, 1, packets required for an axon to fire; must be >= 1
NUM_PORTS, 2, independent packet write ports
CW, $clog2(VOTE_NUM+1), counter width (derived, not overridden)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low
wen  in  NUM_PORTS  per-port packet valid
packet  in  NUM_PORTS*(AW+TW)  port p occupies bits [p*(AW+TW) +: AW+TW]; layout {axon[AW-1:0], dtick[TW-1:0]}
set  in  1  tick pulse: deliver current slot, then advance
clr  in  1  clear axon_spikes register
clr_avr  in  1  flush all counters and the ring pointer
clr_spiked  in  1  clear fired_mask
axon_spikes  out  NUM_AXONS  spikes delivered for the current tick
fired_mask  out  NUM_AXONS  sticky OR of all delivered spikes since the last clr_spiked
rd_ptr  out  TW  slot delivered on the next set
error  out  1  sticky: a packet was dropped

Behaviour:
- Reset (rst=0, asynchronous):
  - all counters, axon_spikes, fired_mask, rd_ptr and error go to 0.
  - Outputs are registered, so all outputs read 0 during reset.
- Slot mapping:
  - target slot = (rd_ptr + dtick) mod NUM_TICKS, using the rd_ptr value before any same-cycle advance.
  - dtick=0 means the packet is delivered by the next set.
- Write:
  - every port with wen=1 increments counter[slot][axon] by 1.
  - Hits in the same cycle (same axon and slot) from multiple ports add together.
  - The sum saturates at VOTE_NUM; it never wraps.
  - The counter is updated at the next clock edge.
- set (single-cycle pulse):
  - axon_spikes[i] <= (counter[rd_ptr][i] + same-cycle increments to slot rd_ptr, axon i) >= VOTE_NUM.
  - Same-cycle packets to the delivered slot are therefore never lost.
  - slot rd_ptr is zeroed, including those same-cycle increments.
  - rd_ptr <= rd_ptr + 1 mod NUM_TICKS; it wraps from NUM_TICKS-1 to 0.
  - fired_mask <= fired_mask | new axon_spikes.
- Latency: set at edge n gives valid axon_spikes and fired_mask after edge n+1. A write at edge n is counted from edge n+1.
- Writes at the same edge to other slots are unaffected by set.
- clr: axon_spikes <= 0. If set and clr are asserted together, set wins and the new vector is loaded.
- clr_spiked: fired_mask <= 0. If set and clr_spiked are asserted together, fired_mask <= new axon_spikes.
- clr_avr (highest priority):
  - all counters <= 0, rd_ptr <= 0, axon_spikes <= 0.
  - Any set asserted with it is ignored.
  - Any wen asserted in the same cycle is dropped and error <= 1.
  - fired_mask is untouched.
- error: cleared only by rst.
- VOTE_NUM=1 degenerates to a plain bit scheduler; CW=1.
- Storage is flops, NUM_TICKS*NUM_AXONS*CW bits. No RAM inference is required.

Test Plan:
- Single vote: reset, then VOTE_NUM=1, port0 packet {axon=5, dtick=0}, then set -> axon_spikes=1<<5, fired_mask bit5=1, rd_ptr=1. A second set gives axon_spikes=0.
- Voting: VOTE_NUM=3, ports 0 and 1 both send {axon=7, dtick=2} in one cycle, then one more {axon=7, dtick=2}. Two sets give axon_spikes=0. The third set gives bit7=1. A repeat with only 2 packets gives bit7=0.
- Same-cycle deliver: VOTE_NUM=2, one stored packet {axon=3, dtick=0}. A second {axon=3, dtick=0} arrives in the same cycle as set -> axon_spikes bit3=1. Slot 0 reads zero after 16 further sets.
- Wrap: with rd_ptr=15, packet {axon=9, dtick=3} targets slot 2. Four sets -> bit9 fires exactly on the fourth, rd_ptr=3.
- Flush and error: queue spikes in slots 0..5, then assert clr_avr with wen=1 -> rd_ptr=0, error=1, and six sets yield all-zero vectors. fired_mask is retained until clr_spiked.
- Async reset mid-run: assert rst=0 between edges -> all outputs 0 immediately. Release rst, then set -> axon_spikes=0.
